// File: rtl/missile_hit_rx_pkg.sv
// Shared game definitions: sprite sizes, coordinate width and dragon state encoding.
// Used by the hit receiver and by the missile and dragon movers.
package missile_hit_rx_pkg;

  localparam int COORD_W   = 10;
  localparam int MISSILE_W = 20;
  localparam int MISSILE_H = 10;
  localparam int DRAGON_W  = 80;
  localparam int DRAGON_H  = 60;

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'b00,
    ST_HURT    = 2'b01,
    ST_DEAD    = 2'b10,
    ST_ILLEGAL = 2'b11
  } dragon_state_e;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle intersection test.
// Sums are widened by one bit so a sprite near the right/bottom edge never wraps.
module rect_overlap
  import missile_hit_rx_pkg::*;
#(
  parameter int AW = MISSILE_W,
  parameter int AH = MISSILE_H,
  parameter int BW = DRAGON_W,
  parameter int BH = DRAGON_H
) (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               overlap
);

  localparam int SW = COORD_W + 1;

  logic [SW-1:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};

  assign overlap = (ax < bx + SW'(BW)) &&
                   (ax + SW'(AW) > bx) &&
                   (ay < by + SW'(BH)) &&
                   (ay + SW'(AH) > by);

endmodule

// File: rtl/missile_hit_rx.sv
// Dragon hit receiver: registers missile hits, tracks hit points and runs the
// ALIVE/HURT/DEAD life cycle with a timed invulnerability window.
module missile_hit_rx
  import missile_hit_rx_pkg::*;
#(
  parameter int MW          = MISSILE_W,
  parameter int MH          = MISSILE_H,
  parameter int DW          = DRAGON_W,
  parameter int DH          = DRAGON_H,
  parameter int HP_INIT     = 5,
  parameter int HURT_CYCLES = 8
) (
  input  logic               clk_22,
  input  logic               rst,
  input  logic [COORD_W-1:0] m_x,
  input  logic [COORD_W-1:0] m_y,
  input  logic               show_valid,
  input  logic [COORD_W-1:0] d_x,
  input  logic [COORD_W-1:0] d_y,
  input  logic               restart,
  output logic               hit_ack,
  output logic [3:0]         hp,
  output logic [1:0]         dragon_state,
  output logic               flash,
  output logic               dead
);

  localparam logic [3:0] HP_RST   = 4'(HP_INIT);
  localparam logic [7:0] HURT_END = 8'(HURT_CYCLES - 1);

  dragon_state_e state_q, state_d;
  logic [3:0]    hp_q, hp_d;
  logic [7:0]    hurt_cnt_q, hurt_cnt_d;
  logic          hit_ack_q, hit_ack_d;
  logic          flash_q, flash_d;
  logic          dead_q, dead_d;
  logic          overlap;
  logic          hit;

  rect_overlap #(
    .AW(MW),
    .AH(MH),
    .BW(DW),
    .BH(DH)
  ) u_rect_overlap (
    .a_x    (m_x),
    .a_y    (m_y),
    .b_x    (d_x),
    .b_y    (d_y),
    .overlap(overlap)
  );

  // Only an ALIVE dragon can be hit; HURT ignores overlap so one missile counts once.
  assign hit = overlap && show_valid && (state_q == ST_ALIVE) && !restart;

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    hurt_cnt_d = hurt_cnt_q;
    hit_ack_d  = 1'b0;
    if (restart) begin
      state_d    = ST_ALIVE;
      hp_d       = HP_RST;
      hurt_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            hit_ack_d  = 1'b1;
            hurt_cnt_d = 8'd0;
            if (hp_q <= 4'd1) begin
              hp_d    = 4'd0;
              state_d = ST_DEAD;
            end else begin
              hp_d    = hp_q - 4'd1;
              state_d = ST_HURT;
            end
          end
        end
        ST_HURT: begin
          if (hurt_cnt_q == HURT_END) begin
            state_d    = ST_ALIVE;
            hurt_cnt_d = 8'd0;
          end else begin
            hurt_cnt_d = hurt_cnt_q + 8'd1;
          end
        end
        ST_DEAD: begin
          state_d = ST_DEAD;
        end
        default: begin
          state_d    = ST_ALIVE;
          hurt_cnt_d = 8'd0;
        end
      endcase
    end
    flash_d = (state_d == ST_HURT) && hurt_cnt_d[1];
    dead_d  = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ALIVE;
      hp_q       <= HP_RST;
      hurt_cnt_q <= 8'd0;
      hit_ack_q  <= 1'b0;
      flash_q    <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      hurt_cnt_q <= hurt_cnt_d;
      hit_ack_q  <= hit_ack_d;
      flash_q    <= flash_d;
      dead_q     <= dead_d;
    end
  end

  assign hit_ack      = hit_ack_q;
  assign hp           = hp_q;
  assign dragon_state = state_q;
  assign flash        = flash_q;
  assign dead         = dead_q;

endmodule

// File: doc/missile_hit_rx.md
MISSILE_HIT_RX -- requirements
Module: missile_hit_rx

Interface
REQ-001 Parameter MW, 20, missile sprite width in pixels.
REQ-002 Parameter MH, 10, missile sprite height in pixels.
REQ-003 Parameter DW, 80, dragon sprite width in pixels.
REQ-004 Parameter DH, 60, dragon sprite height in pixels.
REQ-005 Parameter HP_INIT, 5, dragon hit points after reset or restart; range 1..15.
REQ-006 Parameter HURT_CYCLES, 8, invulnerability length in clk_22 cycles; range 2..255.
REQ-007 clk_22  in  1  game tick clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous reset, active-low.
REQ-009 m_x, m_y  in  10 each  missile top-left pixel.
REQ-010 show_valid  in  1  missile in flight; a missile is hittable only while this is high.
REQ-011 d_x, d_y  in  10 each  dragon top-left pixel.
REQ-012 restart  in  1  level pulse; revives the dragon.
REQ-013 hit_ack  out  1  one-cycle pulse: missile consumed; the missile owner must leave flight on it.
REQ-014 hp  out  4  current hit points.
REQ-015 dragon_state  out  2  00 ALIVE, 01 HURT, 10 DEAD; 11 is illegal.
REQ-016 flash  out  1  sprite blink enable.
REQ-017 dead  out  1  high while dragon_state is DEAD.

Function
REQ-018 overlap SHALL be combinational and true when all four hold: m_x < d_x+DW, m_x+MW > d_x, m_y < d_y+DH, m_y+MH > d_y.
REQ-019 All sums in REQ-018 SHALL be evaluated in 11 bits so that no compare wraps.
REQ-020 hit SHALL be defined as overlap AND show_valid AND dragon_state==ALIVE AND NOT restart.
REQ-021 If hit is true at edge N, then hit_ack SHALL be 1 for exactly cycle N+1, hp SHALL be decremented at N, and the state SHALL move to HURT.
REQ-022 If hp==1 when a hit is registered, the state SHALL move to DEAD instead of HURT and hp SHALL become 0.
REQ-023 hp SHALL never underflow below 0.
REQ-024 Entering HURT SHALL load hurt_cnt with 0; hurt_cnt SHALL increment each cycle while in HURT.
REQ-025 When hurt_cnt==HURT_CYCLES-1, the state SHALL return to ALIVE at the next edge.
REQ-026 In HURT, overlap SHALL be ignored: no hp change and no hit_ack; this blocks double-counting of one missile.
REQ-027 flash SHALL equal hurt_cnt[1] while in HURT and 0 otherwise.
REQ-028 DEAD SHALL hold, with hit_ack=0 and flash=0, until restart.
REQ-029 restart high at an edge, from any state, SHALL set the state to ALIVE, set hp to HP_INIT and clear hurt_cnt.
REQ-030 restart SHALL win over a simultaneous hit; no hit_ack is emitted in that case.
REQ-031 A sustained overlap SHALL produce at most one hit_ack per ALIVE entry.
REQ-032 The illegal state 11 SHALL recover to ALIVE at the next edge.

Reset
REQ-033 When rst is low, the block SHALL take: state ALIVE, hp=HP_INIT, hurt_cnt=0, hit_ack=0, flash=0, dead=0.
REQ-034 rst SHALL assert asynchronously; reset taken mid-HURT SHALL abort the invulnerability window immediately.

Structure
REQ-035 The state encodings (ALIVE, HURT, DEAD) and the sprite size constants SHALL live in a shared game package, also used by the missile and dragon movers.
REQ-036 The REQ-018 rectangle test SHALL be one sub-module, rect_overlap, purely combinational and reused for robot/dragon contact.

Verification
REQ-037 Head-on hit: HP_INIT=5, d=(300,200), m=(290,210), show_valid=1 -> hit_ack one cycle, hp=4, state HURT.
REQ-038 Sustained overlap: hold the REQ-037 overlap for 8 cycles -> only one hit_ack; after 8 cycles state ALIVE; the next edge gives a second hit_ack with hp=3.
REQ-039 Near-miss boundary: m_x = d_x+DW = 380 -> no hit; m_x=379 -> hit.
REQ-040 Kill: hp=1 and a hit -> hp=0, state DEAD, dead=1; further overlap -> no hit_ack.
REQ-041 Restart priority: hit and restart at the same edge -> state ALIVE, hp=5, hit_ack=0.
REQ-042 Reset mid-HURT: rst low at hurt_cnt=3 -> immediately ALIVE, hp=5, flash=0.
REQ-043 Wrap check: d_x=600, m_x=5 -> no hit.
